// File: rtl/sad_row_gen.sv
// sad_row_gen: 4x4 block SAD producer for 16 horizontal candidates.
// Streams one result row per vertical offset to the min-SAD comparator.
module sad_row_gen #(
  parameter int PIX_W  = 8,
  parameter int BLK    = 4,
  parameter int N_CAND = 16,
  parameter int SUM_W  = 12,
  parameter int REF_N  = N_CAND + BLK - 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      cur_valid,
  input  logic [PIX_W-1:0]          cur_pix,
  output logic                      cur_ready,
  input  logic                      ref_valid,
  input  logic [REF_N*PIX_W-1:0]    ref_row,
  output logic                      ref_ready,
  output logic [N_CAND*SUM_W-1:0]   sum_flat,
  output logic [3:0]                ctrl_wd,
  output logic                      sum_valid,
  input  logic                      sum_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int BW   = $clog2(BLK);
  localparam int PW   = 2 * BW;
  localparam int RW   = $clog2(N_CAND);
  localparam int RS_W = PIX_W + 2;

  localparam logic [PW-1:0] PIX_LAST  = PW'(BLK * BLK - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BLK - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(N_CAND - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ACCUM,
    S_PRESENT
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]    pix_q, pix_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PIX_W-1:0] cur_q [BLK][BLK];
  logic [PIX_W-1:0] cur_d [BLK][BLK];
  logic [SUM_W-1:0] acc_q [N_CAND];
  logic [SUM_W-1:0] acc_d [N_CAND];
  logic [RS_W-1:0]  rsum  [N_CAND];

  logic [N_CAND*SUM_W-1:0] sum_q, sum_d;
  logic [3:0]              ctrl_q, ctrl_d;
  logic                    done_q, done_d;
  logic                    cur_rdy_q, ref_rdy_q;

  function automatic logic [PIX_W-1:0] absd(
    input logic [PIX_W-1:0] a,
    input logic [PIX_W-1:0] b
  );
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Per-PE SAD of the current block row selected by the beat index.
  always_comb begin
    for (int i = 0; i < N_CAND; i++) begin
      rsum[i] = '0;
      for (int c = 0; c < BLK; c++) begin
        rsum[i] = rsum[i] + RS_W'(absd(cur_q[beat_q][c],
                                       ref_row[(i+c)*PIX_W +: PIX_W]));
      end
      acc_d[i] = ((beat_q == '0) ? '0 : acc_q[i]) + SUM_W'(rsum[i]);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    beat_d  = beat_q;
    row_d   = row_q;
    cur_d   = cur_q;
    sum_d   = sum_q;
    ctrl_d  = ctrl_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          pix_d   = '0;
          row_d   = '0;
        end
      end
      S_LOAD: begin
        if (cur_valid) begin
          cur_d[pix_q[PW-1:BW]][pix_q[BW-1:0]] = cur_pix;
          pix_d = pix_q + PW'(1);
          if (pix_q == PIX_LAST) begin
            state_d = S_ACCUM;
            beat_d  = '0;
          end
        end
      end
      S_ACCUM: begin
        if (ref_valid) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == BEAT_LAST) begin
            state_d = S_PRESENT;
            ctrl_d  = 4'(row_q);
            for (int i = 0; i < N_CAND; i++) begin
              sum_d[i*SUM_W +: SUM_W] = acc_d[i];
            end
          end
        end
      end
      S_PRESENT: begin
        if (sum_ready) begin
          if (row_q == ROW_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ACCUM;
            row_d   = row_q + RW'(1);
            beat_d  = '0;
          end
        end
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pix_q     <= '0;
      beat_q    <= '0;
      row_q     <= '0;
      sum_q     <= '0;
      ctrl_q    <= '0;
      done_q    <= 1'b0;
      cur_rdy_q <= 1'b0;
      ref_rdy_q <= 1'b0;
      for (int r = 0; r < BLK; r++) begin
        for (int c = 0; c < BLK; c++) begin
          cur_q[r][c] <= '0;
        end
      end
      for (int i = 0; i < N_CAND; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      beat_q    <= beat_d;
      row_q     <= row_d;
      sum_q     <= sum_d;
      ctrl_q    <= ctrl_d;
      done_q    <= done_d;
      cur_rdy_q <= (state_d == S_LOAD);
      ref_rdy_q <= (state_d == S_ACCUM);
      cur_q     <= cur_d;
      if (state_q == S_ACCUM && ref_valid) begin
        acc_q <= acc_d;
      end
    end
  end

  assign cur_ready = cur_rdy_q;
  assign ref_ready = ref_rdy_q;
  assign sum_flat  = sum_q;
  assign ctrl_wd   = ctrl_q;
  assign sum_valid = (state_q == S_PRESENT);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule
